// File: rtl/fminmax_reduce.sv
// Streaming floating-point min/max reduction over a valid/ready stream.
// One element per cycle; returns the extreme value, its index and NaN/overflow flags.
module fminmax_reduce #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int IDX_W = 8,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_nan,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] CNT_MAX = {IDX_W{1'b1}};

  // Maps sign-magnitude encoding onto an unsigned total order (-inf .. +inf).
  function automatic logic [W-1:0] order_key(input logic [W-1:0] v);
    if (v[W-1]) begin
      order_key = ~v;
    end else begin
      order_key = {1'b1, v[W-2:0]};
    end
  endfunction

  function automatic logic is_nan(input logic [W-1:0] v);
    is_nan = (&v[W-2:MAN_W]) && (|v[MAN_W-1:0]);
  endfunction

  state_t           state_r, state_nxt_s;
  logic [W-1:0]     acc_r, acc_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [IDX_W-1:0] cnt_r, cnt_nxt_s;
  logic             full_r, full_nxt_s;
  logic             nan_r, nan_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic             mode_r, mode_nxt_s;
  logic             beat_s;
  logic             in_nan_s;
  logic             replace_s;

  assign in_ready  = (state_r != DONE);
  assign out_valid = (state_r == DONE);
  assign out_data  = acc_r;
  assign out_idx   = idx_r;
  assign out_nan   = nan_r;
  assign out_ovf   = ovf_r;

  assign beat_s    = in_valid && in_ready;
  assign in_nan_s  = is_nan(in_data);
  assign replace_s = mode_r ? (order_key(in_data) < order_key(acc_r))
                            : (order_key(in_data) > order_key(acc_r));

  // Next-state and accumulator update for the reduction FSM.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    full_nxt_s  = full_r;
    nan_nxt_s   = nan_r;
    ovf_nxt_s   = ovf_r;
    mode_nxt_s  = mode_r;
    case (state_r)
      IDLE: begin
        if (beat_s) begin
          acc_nxt_s   = in_nan_s ? QNAN : in_data;
          idx_nxt_s   = {IDX_W{1'b0}};
          cnt_nxt_s   = {{(IDX_W-1){1'b0}}, 1'b1};
          full_nxt_s  = 1'b0;
          nan_nxt_s   = in_nan_s;
          ovf_nxt_s   = 1'b0;
          mode_nxt_s  = mode;
          state_nxt_s = in_last ? DONE : ACC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (beat_s) begin
          // full_r marks that index CNT_MAX is already taken; later beats overflow.
          ovf_nxt_s = ovf_r | full_r;
          if (cnt_r == CNT_MAX) begin
            full_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
          if (nan_r) begin
            acc_nxt_s = acc_r;
          end else if (in_nan_s) begin
            acc_nxt_s = QNAN;
            idx_nxt_s = cnt_r;
            nan_nxt_s = 1'b1;
          end else if (replace_s) begin
            acc_nxt_s = in_data;
            idx_nxt_s = cnt_r;
          end else begin
            acc_nxt_s = acc_r;
          end
          state_nxt_s = in_last ? DONE : ACC;
        end else begin
          state_nxt_s = ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= {W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      cnt_r   <= {IDX_W{1'b0}};
      full_r  <= 1'b0;
      nan_r   <= 1'b0;
      ovf_r   <= 1'b0;
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      idx_r   <= idx_nxt_s;
      cnt_r   <= cnt_nxt_s;
      full_r  <= full_nxt_s;
      nan_r   <= nan_nxt_s;
      ovf_r   <= ovf_nxt_s;
      mode_r  <= mode_nxt_s;
    end
  end

endmodule

// File: tb/tb_fminmax_reduce.sv
// Directed bench for fminmax_reduce: default instance plus an IDX_W=2 instance
// for the index saturation / overflow case.
module tb_fminmax_reduce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  out_idx;
  logic        out_nan;
  logic        out_ovf;

  logic        s_rst = 1'b1;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [31:0] s_in_data = 32'h0;
  logic        s_in_last = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [31:0] s_out_data;
  logic [1:0]  s_out_idx;
  logic        s_out_nan;
  logic        s_out_ovf;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fminmax_reduce dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_nan(out_nan), .out_ovf(out_ovf)
  );

  fminmax_reduce #(.EXP_W(8), .MAN_W(23), .IDX_W(2)) dut_small (
    .clk(clk), .rst(s_rst), .mode(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_idx(s_out_idx), .out_nan(s_out_nan), .out_ovf(s_out_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send(input logic [31:0] d, input logic last, input logic m);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode     = m;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] d, input logic [7:0] idx,
                               input logic nan, input logic ovf);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"},  64'(out_data), 64'(d));
    check({tag, "_idx"},   64'(out_idx), 64'(idx));
    check({tag, "_nan"},   64'(out_nan), 64'(nan));
    check({tag, "_ovf"},   64'(out_ovf), 64'(ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data), 64'd0);
    check("rst_idx",   64'(out_idx), 64'd0);
    check("rst_flags", 64'({out_nan, out_ovf}), 64'd0);
    rst = 1'b0;
    s_rst = 1'b0;
    @(negedge clk);

    // Max with negative element and a tie at the end.
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'hC0000000, 1'b0, 1'b0);
    send(32'h40600000, 1'b0, 1'b0);
    send(32'h40600000, 1'b1, 1'b0);
    expect_result("t1", 32'h40600000, 8'd2, 1'b0, 1'b0);

    // Signed zeros under min and max.
    send(32'h00000000, 1'b0, 1'b1);
    send(32'h80000000, 1'b1, 1'b1);
    expect_result("t2min", 32'h80000000, 8'd1, 1'b0, 1'b0);
    send(32'h00000000, 1'b0, 1'b0);
    send(32'h80000000, 1'b1, 1'b0);
    expect_result("t2max", 32'h00000000, 8'd0, 1'b0, 1'b0);

    // NaN is sticky and canonicalised; later +inf does not replace it.
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h7FC00001, 1'b0, 1'b0);
    send(32'h7F800000, 1'b1, 1'b0);
    expect_result("t3", 32'h7FC00000, 8'd1, 1'b1, 1'b0);

    // Single-beat vector held under backpressure.
    send(32'h7F800000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_data",  64'(out_data), 64'h7F800000);
      check("t4_hold_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    expect_result("t4", 32'h7F800000, 8'd0, 1'b0, 1'b0);

    // Reset mid-vector discards the partial result.
    send(32'h40000000, 1'b0, 1'b0);
    send(32'h40400000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_ready", 64'(in_ready), 64'd1);
    check("t5_rst_data",  64'(out_data), 64'd0);
    send(32'hFF800000, 1'b0, 1'b0);
    send(32'hBF800000, 1'b1, 1'b0);
    expect_result("t5", 32'hBF800000, 8'd1, 1'b0, 1'b0);

    // Mode is latched on the first element; a mid-vector change is ignored.
    send(32'h40000000, 1'b0, 1'b1);
    send(32'h40400000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b1, 1'b0);
    expect_result("t7", 32'h3F800000, 8'd2, 1'b0, 1'b0);

    // IDX_W=2: five ascending beats overflow and saturate the index.
    for (int i = 0; i < 5; i++) begin
      logic [31:0] vals [5];
      vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
      s_in_valid = 1'b1;
      s_in_data  = vals[i];
      s_in_last  = (i == 4);
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
    check("t6_valid", 64'(s_out_valid), 64'd1);
    check("t6_data",  64'(s_out_data), 64'h40A00000);
    check("t6_idx",   64'(s_out_idx), 64'd3);
    check("t6_ovf",   64'(s_out_ovf), 64'd1);
    check("t6_nan",   64'(s_out_nan), 64'd0);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check("t6_idle", 64'(s_out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
